// File: rtl/tone_gen.sv
// ---------------------------------------------------------------------------
// tone_gen: beep/tone sequencer that drives the sound DAC with 8-bit
// offset-binary samples. It produces a square wave that is symmetric around
// midscale (8'h80), paced by a free-running sample tick. The DAC is returned
// to midscale after reset and at the end of every tone.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   cmd_valid       tone command present
//   cmd_ready       block can accept a command (high only in IDLE)
//   cmd_half_period samples per half cycle (0 behaves as 1)
//   cmd_duration    tone length in samples (0 = no tone, midscale only)
//   cmd_amplitude   peak deviation from midscale
//   abort           stop the current tone (ignored outside PLAY)
//   dac_data        sample to the DAC
//   dac_valid       one-cycle strobe to the DAC
//   dac_ready       DAC idle
//   busy            high in any state other than IDLE
//   overrun_cnt     saturating count of samples lost to DAC backpressure
// ---------------------------------------------------------------------------
module tone_gen #(
  parameter int SAMPLE_DIV = 2500,
  parameter int HP_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [HP_W-1:0] cmd_half_period,
  input  logic [HP_W-1:0] cmd_duration,
  input  logic [6:0]      cmd_amplitude,
  input  logic            abort,
  output logic [7:0]      dac_data,
  output logic            dac_valid,
  input  logic            dac_ready,
  output logic            busy,
  output logic [7:0]      overrun_cnt
);

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_DONE      = 3'd3;
  localparam logic [2:0] ST_DONE_WAIT = 3'd4;

  localparam logic [7:0]      MID      = 8'h80;
  localparam logic [15:0]     DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [HP_W-1:0] HP_ONE   = HP_W'(1);

  logic [2:0]      state_q, state_d;
  logic [15:0]     div_q, div_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [HP_W-1:0] rem_q, rem_d;
  logic [HP_W-1:0] pcnt_q, pcnt_d;
  logic [6:0]      amp_q, amp_d;
  logic            phase_q, phase_d;
  logic [7:0]      data_q, data_d;
  logic            pend_q, pend_d;
  logic [7:0]      ovr_q, ovr_d;

  logic            tick;
  logic            req;
  logic [7:0]      req_val;

  // Square-wave level for the current phase; amp is 7 bits so neither
  // direction can wrap.
  function automatic logic [7:0] tone_level(input logic high, input logic [6:0] amp);
    return high ? (MID + {1'b0, amp}) : (MID - {1'b0, amp});
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  always_comb begin
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? 16'd0 : (div_q + 16'd1);

    state_d = state_q;
    hp_d    = hp_q;
    rem_d   = rem_q;
    pcnt_d  = pcnt_q;
    amp_d   = amp_q;
    phase_d = phase_q;
    req     = 1'b0;
    req_val = MID;
    cmd_ready = 1'b0;

    case (state_q)
      ST_INIT: begin
        req     = 1'b1;
        state_d = ST_DONE_WAIT;
      end
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          hp_d    = (cmd_half_period == '0) ? HP_ONE : cmd_half_period;
          rem_d   = cmd_duration;
          amp_d   = cmd_amplitude;
          phase_d = 1'b1;
          pcnt_d  = '0;
          state_d = (cmd_duration == '0) ? ST_DONE : ST_PLAY;
        end
      end
      ST_PLAY: begin
        // abort wins over a coincident tick: that tick's sample is dropped
        if (abort) begin
          state_d = ST_DONE;
        end else if (tick) begin
          req     = 1'b1;
          req_val = tone_level(phase_q, amp_q);
          if (pcnt_q == hp_q - HP_ONE) begin
            pcnt_d  = '0;
            phase_d = ~phase_q;
          end else begin
            pcnt_d  = pcnt_q + HP_ONE;
          end
          rem_d = rem_q - HP_ONE;
          if (rem_q == HP_ONE) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        req     = 1'b1;
        state_d = ST_DONE_WAIT;
      end
      ST_DONE_WAIT: begin
        if (!pend_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Sample delivery: a request always overwrites the held sample. It only
    // counts as lost when the held one is not leaving in this same cycle.
    dac_valid = pend_q & dac_ready;
    data_d    = data_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    if (req) begin
      data_d = req_val;
      pend_d = 1'b1;
      if (pend_q && !dac_ready) begin
        ovr_d = sat_inc(ovr_q);
      end
    end else if (dac_valid) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      div_q   <= '0;
      hp_q    <= HP_ONE;
      rem_q   <= '0;
      pcnt_q  <= '0;
      amp_q   <= '0;
      phase_q <= 1'b1;
      data_q  <= MID;
      pend_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      rem_q   <= rem_d;
      pcnt_q  <= pcnt_d;
      amp_q   <= amp_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dac_data    = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_tone_gen.sv
module tb_tone_gen;
  localparam int SDIV = 8;
  localparam int HP_W = 16;

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [HP_W-1:0] cmd_half_period;
  logic [HP_W-1:0] cmd_duration;
  logic [6:0]      cmd_amplitude;
  logic            abort;
  logic [7:0]      dac_data;
  logic            dac_valid;
  logic            dac_ready;
  logic            busy;
  logic [7:0]      overrun_cnt;

  tone_gen #(.SAMPLE_DIV(SDIV), .HP_W(HP_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_half_period (cmd_half_period),
    .cmd_duration    (cmd_duration),
    .cmd_amplitude   (cmd_amplitude),
    .abort           (abort),
    .dac_data        (dac_data),
    .dac_valid       (dac_valid),
    .dac_ready       (dac_ready),
    .busy            (busy),
    .overrun_cnt     (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] obs_q[$];
  int         obs_t[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && dac_valid) begin
      obs_q.push_back(dac_data);
      obs_t.push_back(cyc);
    end
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_cmd(input int hp, input int dur, input int amp);
    @(posedge clk); #1;
    cmd_valid       = 1'b1;
    cmd_half_period = HP_W'(hp);
    cmd_duration    = HP_W'(dur);
    cmd_amplitude   = 7'(amp);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    logic [7:0] o, e;
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; dac_ready = 1'b1;
    cmd_half_period = '0; cmd_duration = '0; cmd_amplitude = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (dac_data !== 8'h80) $display("FAIL rst_dac_data: got %h expected 80", dac_data); else pass_cnt++;
    total_cnt++; if (dac_valid !== 1'b0) $display("FAIL rst_dac_valid: got %b expected 0", dac_valid); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", busy); else pass_cnt++;
    total_cnt++; if (overrun_cnt !== 8'h00) $display("FAIL rst_overrun: got %0d expected 0", overrun_cnt); else pass_cnt++;
    exp_q.push_back(8'h80);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_obs(1, 40, ok);
    wait_ready(40, ok);
    total_cnt++; if (!ok) $display("FAIL rst_to_idle: cmd_ready %b expected 1 within budget", cmd_ready); else pass_cnt++;
    repeat (12) @(negedge clk); #1;
    total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL rst_count: got %0d samples expected %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL rst_sample: got %h expected %h", o, e); else pass_cnt++;
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    total_cnt++; if (overrun_cnt !== 8'h00) $display("FAIL rst_overrun_after: got %0d expected 0", overrun_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy_after: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_tone();
    bit ok;
    logic [7:0] o, e;
    logic [7:0] pat [7] = '{8'hC0, 8'hC0, 8'h40, 8'h40, 8'hC0, 8'hC0, 8'h80};
    foreach (pat[i]) exp_q.push_back(pat[i]);
    send_cmd(2, 6, 7'h40);
    wait_obs(1, 40, ok);
    // a command offered mid-tone must be held off
    cmd_valid = 1'b1; cmd_duration = HP_W'(1);
    @(negedge clk);
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL tone_hold_off: cmd_ready %b expected 0", cmd_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL tone_busy: got %b expected 1", busy); else pass_cnt++;
    #1 cmd_valid = 1'b0;
    wait_obs(7, 200, ok);
    wait_ready(40, ok);
    total_cnt++; if (!ok) $display("FAIL tone_to_idle: cmd_ready %b expected 1 within budget", cmd_ready); else pass_cnt++;
    repeat (12) @(negedge clk); #1;
    total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL tone_count: got %0d samples expected %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i + 1 < 6 && i + 1 < obs_t.size(); i++) begin
      total_cnt++;
      if (obs_t[i+1] - obs_t[i] !== SDIV) $display("FAIL tone_spacing: got %0d cycles expected %0d", obs_t[i+1] - obs_t[i], SDIV); else pass_cnt++;
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL tone_sample: got %h expected %h", o, e); else pass_cnt++;
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    total_cnt++; if (busy !== 1'b0) $display("FAIL tone_busy_after: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_hp_zero();
    bit ok;
    logic [7:0] o, e;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'hFF); exp_q.push_back(8'h80);
    send_cmd(0, 3, 7'h7F);
    wait_obs(4, 200, ok);
    wait_ready(40, ok);
    total_cnt++; if (!ok) $display("FAIL hp0_to_idle: cmd_ready %b expected 1 within budget", cmd_ready); else pass_cnt++;
    repeat (12) @(negedge clk); #1;
    total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL hp0_count: got %0d samples expected %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL hp0_sample: got %h expected %h", o, e); else pass_cnt++;
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  task automatic test_dur_zero();
    bit ok;
    logic [7:0] o, e;
    exp_q.push_back(8'h80);
    send_cmd(3, 0, 7'h55);
    wait_obs(1, 100, ok);
    wait_ready(40, ok);
    total_cnt++; if (!ok) $display("FAIL dur0_to_idle: cmd_ready %b expected 1 within budget", cmd_ready); else pass_cnt++;
    repeat (20) @(negedge clk); #1;
    total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL dur0_count: got %0d samples expected %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL dur0_sample: got %h expected %h", o, e); else pass_cnt++;
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  task automatic test_abort();
    bit ok;
    logic [7:0] o, e;
    exp_q.push_back(8'h90); exp_q.push_back(8'h90); exp_q.push_back(8'h90); exp_q.push_back(8'h80);
    send_cmd(4, 100, 7'h10);
    wait_obs(3, 200, ok);
    // 3rd sample strobes one cycle after its tick, so the 4th tick is 7 cycles on
    repeat (7) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_obs(4, 100, ok);
    wait_ready(40, ok);
    total_cnt++; if (!ok) $display("FAIL abort_to_idle: cmd_ready %b expected 1 within budget", cmd_ready); else pass_cnt++;
    repeat (20) @(negedge clk); #1;
    total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL abort_count: got %0d samples expected %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL abort_sample: got %h expected %h", o, e); else pass_cnt++;
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    // abort in IDLE must not disturb anything
    abort = 1'b1;
    repeat (3) @(negedge clk); #1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL abort_idle: cmd_ready %b expected 1", cmd_ready); else pass_cnt++;
    abort = 1'b0;
  endtask

  task automatic test_overrun();
    bit ok;
    logic [7:0] o, e;
    logic [7:0] pat [9] = '{8'hA0, 8'h60, 8'hA0, 8'hA0, 8'h60, 8'h60, 8'hA0, 8'hA0, 8'h80};
    foreach (pat[i]) exp_q.push_back(pat[i]);
    send_cmd(2, 10, 7'h20);
    wait_obs(1, 40, ok);
    // hold the DAC off across three ticks: one held, two lost
    repeat (7) @(posedge clk);
    #1 dac_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1 dac_ready = 1'b1;
    wait_obs(9, 400, ok);
    wait_ready(40, ok);
    total_cnt++; if (!ok) $display("FAIL ovr_to_idle: cmd_ready %b expected 1 within budget", cmd_ready); else pass_cnt++;
    repeat (12) @(negedge clk); #1;
    total_cnt++; if (overrun_cnt !== 8'd2) $display("FAIL ovr_count: got %0d expected 2", overrun_cnt); else pass_cnt++;
    total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL ovr_samples: got %0d samples expected %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL ovr_sample: got %h expected %h", o, e); else pass_cnt++;
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] o, e;
    exp_q.push_back(8'h85); exp_q.push_back(8'h85); exp_q.push_back(8'h80);
    send_cmd(2, 50, 7'h05);
    wait_obs(2, 100, ok);
    #1 rst_n = 1'b0;
    #1;
    total_cnt++; if (dac_data !== 8'h80) $display("FAIL mid_rst_data: got %h expected 80", dac_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL mid_rst_busy: got %b expected 1", busy); else pass_cnt++;
    total_cnt++; if (overrun_cnt !== 8'h00) $display("FAIL mid_rst_overrun: got %0d expected 0", overrun_cnt); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b expected 0", cmd_ready); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_obs(3, 40, ok);
    wait_ready(40, ok);
    total_cnt++; if (!ok) $display("FAIL mid_rst_to_idle: cmd_ready %b expected 1 within budget", cmd_ready); else pass_cnt++;
    repeat (12) @(negedge clk); #1;
    total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL mid_rst_count: got %0d samples expected %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL mid_rst_sample: got %h expected %h", o, e); else pass_cnt++;
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_tone();
    test_hp_zero();
    test_dur_zero();
    test_abort();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Beep/tone sequencer that feeds the sound spi_dac (dac_a/synca_n path) with 8-bit offset-binary samples.
- Accepts tone commands (half-period, duration, amplitude) from the NIOS-side control logic through a valid/ready handshake.
- Paces samples with a fixed sample tick and produces a symmetric square wave around midscale 8'h80.
- Returns the DAC to midscale at the end of every tone and after reset.

Parameters:
- SAMPLE_DIV, 2500: clk cycles per sample tick (20 kHz at 50 MHz). Legal range 2..65535.
- HP_W, 16: width of the half-period and duration fields, in samples.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  tone command present.
- cmd_ready  output  1  block can accept a command.
- cmd_half_period  input  HP_W  samples per half cycle; 0 is treated as 1.
- cmd_duration  input  HP_W  tone length in samples.
- cmd_amplitude  input  7  peak deviation from midscale.
- abort  input  1  stop the current tone immediately.
- dac_data  output  8  sample to spi_dac data_spi.
- dac_valid  output  1  one-cycle strobe to spi_dac valid.
- dac_ready  input  1  spi_dac idle; connected to its dsync_n.
- busy  output  1  high in any state other than IDLE.
- overrun_cnt  output  8  saturating count of samples lost to DAC backpressure.

Behaviour:
- Reset values: state INIT, dac_data 8'h80, dac_valid 0, cmd_ready 0, busy 1, overrun_cnt 0, tick divider 0, pending 0.
- Tick divider: counts 0..SAMPLE_DIV-1 and wraps. It asserts tick for one cycle at the wrap. It runs freely in every state.
- Sample delivery:
  - A "sample request" loads dac_data and sets pending.
  - dac_valid pulses for one cycle in the first cycle where pending=1 and dac_ready=1; pending clears in that same cycle.
  - If pending=1 is already set when a new sample request arrives, the new value overwrites dac_data, pending stays 1, and overrun_cnt increments (saturating at 255).
  - Latency from tick to dac_valid is 1 cycle when dac_ready is held high.
- INIT:
  - Issue a sample request with 8'h80.
  - Go to DONE_WAIT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch hp=max(cmd_half_period,1), remaining duration, amp, and set phase=high with the phase counter at 0.
  - Duration 0: go to DONE (no tone samples). Otherwise go to PLAY.
  - cmd_ready=0 in every other state; commands there are not accepted and are held off.
- PLAY:
  - On each tick, issue a sample request:
    - 8'h80+amp when phase is high.
    - 8'h80-amp when phase is low.
  - The phase counter increments on each tick. When it reaches hp-1 it resets to 0 and phase toggles.
  - The remaining duration decrements on each tick. After the sample with remaining=1, go to DONE.
  - abort=1 in PLAY: go to DONE on the next cycle; no further tone samples.
  - abort has priority over a simultaneous tick (the tick's sample is not issued).
- DONE:
  - Issue a sample request with 8'h80.
  - Go to DONE_WAIT.
- DONE_WAIT:
  - Stay until pending=0, then go to IDLE.
- Arithmetic:
  - amp is 7 bits, so the high level is 8'h80..8'hFF and the low level is 8'h01..8'h80.
  - No overflow is possible.
  - amp=0 gives a constant 8'h80 for the tone duration.
- Reset mid-operation: the asynchronous reset aborts immediately. It restarts at INIT, and one midscale sample is sent once dac_ready is high.
- abort outside PLAY is ignored.

Test Plan:
- Reset release, SAMPLE_DIV=8, dac_ready=1 -> exactly one dac_valid with dac_data=8'h80; cmd_ready=1 afterwards; overrun_cnt=0.
- Command hp=2, dur=6, amp=7'h40 -> samples C0,C0,40,40,C0,C0 on consecutive ticks (8 clk apart), then 80, busy drops, cmd_ready returns.
- Command hp=0, dur=3, amp=7'h7F -> hp is treated as 1: FF,01,FF, then 80.
- Command dur=0 -> no tone samples; a single 80 sample follows; back to IDLE.
- Command hp=4, dur=100, abort asserted after the 3rd sample, coincident with a tick -> no 4th tone sample; next sample is 80; cmd_ready=1.
- dac_ready held low for 20 clk during PLAY (SAMPLE_DIV=8) -> overrun_cnt=2; the first dac_valid after release carries the latest sample value.
